sqg_sched: RTL

- Level sequencer for the box-count square-generator engine in the multifractal analysis datapath.
- Runs a programmed number of 2x2 coarsening passes over the box-count RAM, one pass per level. Between passes it ping-pongs the source/destination bank.
- Owns the engine hold (BC_mode) line and the RAM port select. Grants the RAM to a host reader only while idle.

---
 rtl/sqg_sched.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sqg_sched.sv
// Level sequencer for the box-count square generator:
// runs one 2x2 coarsening pass per level and arbitrates the RAM.
module sqg_sched #(
  parameter int BOX_IDX  = 3,
  parameter int MAX_BOX  = 3,
  parameter int STEP_CYC = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [BOX_IDX-1:0] levels,
  input  logic               wen_sqg,
  output logic               BC_mode,
  output logic               src_bank,
  output logic [BOX_IDX-1:0] level_idx,
  output logic [BOX_IDX:0]   level_side,
  output logic               busy,
  output logic               lvl_done,
  output logic               done,
  output logic               err,
  input  logic               host_req,
  output logic               host_gnt,
  output logic               ram_sel
);

  localparam int EW      = 2 * BOX_IDX;
  localparam int LIM_MAX = STEP_CYC * ((4 ** (BOX_IDX - 1)) + 2);
  localparam int WW0     = $clog2(LIM_MAX + 1);
  localparam int WW      = (WW0 > EW) ? WW0 : EW;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [BOX_IDX:0]   SIDE0  = (BOX_IDX+1)'(1) << BOX_IDX;
  localparam logic [EW-1:0]      EXP0   = EW'(1) << (EW - 2);
  localparam logic [BOX_IDX-1:0] LV_MAX = BOX_IDX'(BOX_IDX - 1);

  if (MAX_BOX < BOX_IDX) begin : g_bad_cfg
    $error("sqg_sched: MAX_BOX must be >= BOX_IDX");
  end

  logic [2:0]         state_q, state_d;
  logic [BOX_IDX-1:0] lvls_q, lvls_d;
  logic [BOX_IDX-1:0] level_idx_q, level_idx_d;
  logic               src_bank_q, src_bank_d;
  logic               err_q, err_d;
  logic [EW-1:0]      exp_q, exp_d;
  logic [WW-1:0]      lim_q, lim_d;
  logic [EW-1:0]      wr_cnt_q, wr_cnt_d;
  logic [WW-1:0]      wd_cnt_q, wd_cnt_d;
  logic               start_ok;
  logic               last_wr;

  assign start_ok = (state_q == S_IDLE) && start &&
                    (levels != '0) && (levels <= LV_MAX);
  assign last_wr  = wen_sqg && (wr_cnt_q == exp_q - EW'(1));

  always_comb begin
    state_d     = state_q;
    lvls_d      = lvls_q;
    level_idx_d = level_idx_q;
    src_bank_d  = src_bank_q;
    err_d       = 1'b0;
    exp_d       = exp_q;
    lim_d       = lim_q;
    wr_cnt_d    = wr_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          lvls_d      = levels;
          level_idx_d = '0;
          src_bank_d  = 1'b0;
          state_d     = S_LOAD;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_LOAD: begin
        wr_cnt_d = '0;
        wd_cnt_d = '0;
        // exp = 4^(BOX_IDX-1-level_idx)
        exp_d    = EXP0 >> {level_idx_q, 1'b0};
        lim_d    = WW'(STEP_CYC) * (WW'(exp_d) + WW'(2));
        state_d  = S_RUN;
      end
      S_RUN: begin
        wd_cnt_d = wd_cnt_q + WW'(1);
        if (wen_sqg) wr_cnt_d = wr_cnt_q + EW'(1);
        if (last_wr) begin
          state_d = S_DRAIN;
        end else if (wd_cnt_d == lim_q) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (level_idx_q + BOX_IDX'(1) < lvls_q) begin
          level_idx_d = level_idx_q + BOX_IDX'(1);
          src_bank_d  = ~src_bank_q;
          state_d     = S_LOAD;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lvls_q      <= '0;
      level_idx_q <= '0;
      src_bank_q  <= 1'b0;
      err_q       <= 1'b0;
      exp_q       <= '0;
      lim_q       <= '0;
      wr_cnt_q    <= '0;
      wd_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      lvls_q      <= lvls_d;
      level_idx_q <= level_idx_d;
      src_bank_q  <= src_bank_d;
      err_q       <= err_d;
      exp_q       <= exp_d;
      lim_q       <= lim_d;
      wr_cnt_q    <= wr_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
    end
  end

  assign BC_mode    = (state_q != S_RUN);
  assign ram_sel    = (state_q == S_IDLE);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RUN) ||
                      (state_q == S_DRAIN);
  assign lvl_done   = (state_q == S_DRAIN);
  assign done       = (state_q == S_FIN);
  assign err        = err_q;
  assign src_bank   = src_bank_q;
  assign level_idx  = level_idx_q;
  assign level_side = SIDE0 >> level_idx_q;
  // an accepted start takes the RAM ahead of a pending host request
  assign host_gnt   = (state_q == S_IDLE) && host_req && !start_ok && !RST;

endmodule
